// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage execute unit fed by the ALU control decoder.
//   and/or/add/sub produce a registered result one cycle after acceptance.
//   mul runs as an iterative radix-2 shift-add over up to WIDTH cycles while busy_o is high.
//
// Optional feature macro: ALU_MUL_EARLY_EXIT_EN
//   When defined, mul also finishes once the remaining multiplier bits are all zero
//   (minimum one MUL cycle). The result is unchanged; only the latency depends on the data.
//
// Ports:
//   clk_i      clock, all state updates on the rising edge
//   rst_i      synchronous active-high reset
//   start_i    op/operands valid; accepted only while busy_o is low
//   aluctrl_i  000 and, 001 or, 010 add, 110 sub, 011 mul (others give 0)
//   data1_i    operand A / multiplicand
//   data2_i    operand B / multiplier
//   data_o     registered result, held until the next valid_o
//   zero_o     registered (data_o == 0)
//   valid_o    one-cycle pulse when data_o/zero_o are new
//   busy_o     high while a mul is iterating
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       aluctrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic             valid_o,
    output logic             busy_o
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    localparam logic [2:0] OpAnd = 3'b000;
    localparam logic [2:0] OpOr  = 3'b001;
    localparam logic [2:0] OpAdd = 3'b010;
    localparam logic [2:0] OpSub = 3'b110;
    localparam logic [2:0] OpMul = 3'b011;

    typedef enum logic {
        StIdle = 1'b0,
        StMul  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             zero_q, zero_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0] b_shift;
    logic             mul_done;

    // Single-cycle ops; undefined codes produce zero.
    always_comb begin
        alu_res = '0;
        case (aluctrl_i)
            OpAnd:   alu_res = data1_i & data2_i;
            OpOr:    alu_res = data1_i | data2_i;
            OpAdd:   alu_res = data1_i + data2_i;
            OpSub:   alu_res = data1_i - data2_i;
            default: alu_res = '0;
        endcase
    end

    assign acc_sum = acc_q + (b_q[0] ? a_q : '0);
    assign b_shift = b_q >> 1;

`ifdef ALU_MUL_EARLY_EXIT_EN
    // No multiplier bits left after this step: the accumulator is already final.
    assign mul_done = (cnt_q == CntLast) || (b_shift == '0);
`else
    assign mul_done = (cnt_q == CntLast);
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        zero_d  = zero_q;
        valid_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (aluctrl_i == OpMul) begin
                        a_d     = data1_i;
                        b_d     = data2_i;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = StMul;
                    end else begin
                        data_d  = alu_res;
                        zero_d  = (alu_res == '0);
                        valid_d = 1'b1;
                    end
                end
            end
            StMul: begin
                acc_d = acc_sum;
                a_d   = a_q << 1;
                b_d   = b_shift;
                cnt_d = cnt_q + CntW'(1);
                if (mul_done) begin
                    data_d  = acc_sum;
                    zero_d  = (acc_sum == '0);
                    valid_d = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            zero_q  <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign zero_o  = zero_q;
    assign valid_o = valid_q;
    assign busy_o  = (state_q == StMul);

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

    localparam int unsigned W = 32;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         start_i;
    logic [2:0]   aluctrl_i;
    logic [W-1:0] data1_i;
    logic [W-1:0] data2_i;
    logic [W-1:0] data_o;
    logic         zero_o;
    logic         valid_o;
    logic         busy_o;

    int n_checks = 0;
    int n_fails  = 0;

    alu_exec_unit #(.WIDTH(W)) u_dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .aluctrl_i (aluctrl_i),
        .data1_i   (data1_i),
        .data2_i   (data2_i),
        .data_o    (data_o),
        .zero_o    (zero_o),
        .valid_o   (valid_o),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain arithmetic on the op semantics.
    function automatic logic [W-1:0] ref_result(input logic [2:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        logic [2*W-1:0] prod;
        case (op)
            3'b000: return a & b;
            3'b001: return a | b;
            3'b010: return W'(a + b);
            3'b110: return W'(a - b);
            3'b011: begin
                prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                return prod[W-1:0];
            end
            default: return '0;
        endcase
    endfunction

    // Cycles from the accepting edge until valid_o is seen.
    function automatic int ref_latency(input logic [2:0] op, input logic [W-1:0] b);
        int iters;
        if (op != 3'b011) return 1;
`ifdef ALU_MUL_EARLY_EXIT_EN
        iters = 1;
        while (iters < int'(W) && (b >> iters) != '0) iters++;
`else
        iters = W;
`endif
        return iters + 1;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Issue one op from idle and check result, latency, busy window and one-cycle pulse.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        int lat;
        int busy_cnt;
        int exp_lat;
        logic [W-1:0] exp_res;
        exp_res = ref_result(op, a, b);
        exp_lat = ref_latency(op, b);
        start_i = 1'b1;
        aluctrl_i = op;
        data1_i = a;
        data2_i = b;
        step();
        start_i = 1'b0;
        data1_i = $urandom;
        data2_i = $urandom;
        lat = 1;
        busy_cnt = 0;
        while (!valid_o && lat < 100) begin
            if (busy_o) busy_cnt++;
            step();
            lat++;
        end
        check_eq({tag, " valid"}, 64'(valid_o), 64'(1));
        check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, " data"}, 64'(data_o), 64'(exp_res));
        check_eq({tag, " zero"}, 64'(zero_o), 64'(exp_res == '0));
        check_eq({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
        check_eq({tag, " busy_at_valid"}, 64'(busy_o), 64'(0));
        step();
        check_eq({tag, " pulse_once"}, 64'(valid_o), 64'(0));
        check_eq({tag, " held"}, 64'(data_o), 64'(exp_res));
    endtask

    initial begin
        logic [2:0] ops [8];
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0] op;
        ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b110;
        ops[4] = 3'b011; ops[5] = 3'b100; ops[6] = 3'b101; ops[7] = 3'b111;

        rst_i = 1'b1;
        start_i = 1'b0;
        aluctrl_i = '0;
        data1_i = '0;
        data2_i = '0;
        step();
        step();
        rst_i = 1'b0;
        check_eq("rst data", 64'(data_o), 64'(0));
        check_eq("rst zero", 64'(zero_o), 64'(1));
        check_eq("rst valid", 64'(valid_o), 64'(0));
        check_eq("rst busy", 64'(busy_o), 64'(0));

        run_op("add", 3'b010, 32'd5, 32'd7);
        run_op("sub", 3'b110, 32'd9, 32'd9);
        run_op("and", 3'b000, 32'h0000_F0F0, 32'h0000_0FF0);
        run_op("or", 3'b001, 32'h1, 32'h2);
        run_op("addwrap", 3'b010, 32'hFFFF_FFFF, 32'h2);
        run_op("undef", 3'b101, 32'h1234, 32'h5678);
        run_op("mul6x7", 3'b011, 32'd6, 32'd7);
        run_op("mul9x0", 3'b011, 32'd9, 32'd0);
        run_op("mul9x3", 3'b011, 32'd9, 32'd3);
        run_op("mulmsb", 3'b011, 32'h3, 32'h8000_0001);

        // Back-to-back: new op accepted in the cycle valid_o pulses.
        start_i = 1'b1; aluctrl_i = 3'b010; data1_i = 32'd100; data2_i = 32'd23;
        step();
        check_eq("b2b first valid", 64'(valid_o), 64'(1));
        check_eq("b2b first data", 64'(data_o), 64'(123));
        aluctrl_i = 3'b110; data1_i = 32'd3; data2_i = 32'd5;
        step();
        start_i = 1'b0;
        check_eq("b2b second valid", 64'(valid_o), 64'(1));
        check_eq("b2b second data", 64'(data_o), 64'(32'hFFFF_FFFE));
        step();
        check_eq("b2b idle", 64'(valid_o), 64'(0));

        // start_i during busy is ignored: mul result and latency unaffected, no extra pulse.
        begin
            int lat;
            start_i = 1'b1; aluctrl_i = 3'b011; data1_i = 32'hFFFF_FFFF; data2_i = 32'd2;
            step();
            start_i = 1'b0;
            lat = 1;
            repeat (4) begin step(); lat++; end
            start_i = 1'b1; aluctrl_i = 3'b010; data1_i = 32'd1; data2_i = 32'd1;
            step();
            lat++;
            start_i = 1'b0;
            while (!valid_o && lat < 100) begin step(); lat++; end
            check_eq("ign latency", 64'(lat), 64'(ref_latency(3'b011, 32'd2)));
            check_eq("ign data", 64'(data_o), 64'(32'hFFFF_FFFE));
            repeat (3) begin
                step();
                check_eq("ign no_pulse", 64'(valid_o), 64'(0));
            end
            check_eq("ign held", 64'(data_o), 64'(32'hFFFF_FFFE));
        end

        // Reset mid-mul aborts without a pulse.
        start_i = 1'b1; aluctrl_i = 3'b011; data1_i = 32'd100; data2_i = 32'd100;
        step();
        start_i = 1'b0;
        repeat (9) step();
        check_eq("pre_rst busy", 64'(busy_o), 64'(1));
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check_eq("midrst busy", 64'(busy_o), 64'(0));
        check_eq("midrst data", 64'(data_o), 64'(0));
        check_eq("midrst zero", 64'(zero_o), 64'(1));
        check_eq("midrst valid", 64'(valid_o), 64'(0));
        begin
            int pulses;
            pulses = 0;
            repeat (40) begin
                step();
                if (valid_o) pulses++;
            end
            check_eq("midrst no_pulse", 64'(pulses), 64'(0));
        end

        // Randomized ops against the reference model.
        for (int i = 0; i < 30; i++) begin
            op = ops[$urandom_range(0, 7)];
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) a = b;
            run_op($sformatf("rnd%0d op%0b", i, op), op, a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
